// File: rtl/up_hazard_ctrl.sv
// Pipeline hazard controller: scoreboard-based forwarding select, load-use stall,
// taken-branch flush, halt/drain sequencing and a saturating stall counter.
`timescale 1ns/1ps
module up_hazard_ctrl #(
  parameter int RADDR = 3,
  parameter int NFWD  = 2,
  parameter int FSEL  = 2,
  parameter int CNTW  = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             id_valid,
  input  logic [RADDR-1:0] id_src1,
  input  logic [RADDR-1:0] id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RADDR-1:0] id_dest,
  input  logic             id_wen,
  input  logic             id_isload,
  input  logic             id_branch_taken,
  input  logic             id_halt,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic [FSEL-1:0]  fwd1_sel,
  output logic [FSEL-1:0]  fwd2_sel,
  output logic             halted_o,
  output logic [CNTW-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic             isload;
    logic [RADDR-1:0] dest;
  } sb_entry_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  sb_entry_t       sb_q [NFWD];
  sb_entry_t       sb_d [NFWD];
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NFWD-1:0] match1;
  logic [NFWD-1:0] match2;
  logic [NFWD-1:0] valid_vec;
  logic            sb_empty;
  logic            loaduse;
  logic [FSEL-1:0] fwd1_raw;
  logic [FSEL-1:0] fwd2_raw;
  logic            issue;
  logic            stall_int;
  logic            flush_int;
  logic            halted_int;

  // Per-entry source match; register 0 never forwards.
  genvar gi;
  generate
    for (gi = 0; gi < NFWD; gi++) begin : g_match
      assign match1[gi] = sb_q[gi].valid & sb_q[gi].wen &
                          (sb_q[gi].dest == id_src1) & (id_src1 != '0) & id_use1;
      assign match2[gi] = sb_q[gi].valid & sb_q[gi].wen &
                          (sb_q[gi].dest == id_src2) & (id_src2 != '0) & id_use2;
      assign valid_vec[gi] = sb_q[gi].valid;
    end
  endgenerate

  assign sb_empty = ~|valid_vec;
  assign loaduse  = id_valid & (match1[0] | match2[0]) & sb_q[0].isload;

  // Youngest matching writer wins: scan oldest-first so the lowest index lands last.
  always_comb begin
    fwd1_raw = '0;
    fwd2_raw = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (match1[k]) fwd1_raw = FSEL'(k + 1);
      if (match2[k]) fwd2_raw = FSEL'(k + 1);
    end
  end

  always_comb begin
    state_d    = state_q;
    stall_int  = 1'b0;
    flush_int  = 1'b0;
    halted_int = 1'b0;
    issue      = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall_int = loaduse;
        issue     = id_valid & ~loaduse;
        // A HALT that also resolved a taken branch does not flush.
        flush_int = id_valid & id_branch_taken & ~loaduse & ~id_halt;
        if (id_valid & id_halt & ~loaduse) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall_int = 1'b1;
        if (sb_empty) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        stall_int  = 1'b1;
        halted_int = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    sb_d[0] = '0;
    if (issue) begin
      sb_d[0].valid  = 1'b1;
      sb_d[0].wen    = id_wen;
      sb_d[0].isload = id_isload;
      sb_d[0].dest   = id_dest;
    end
    for (int k = 1; k < NFWD; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_RUN) && loaduse && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      for (int k = 0; k < NFWD; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < NFWD; k++) begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

  // Control outputs are held low for as long as reset is asserted.
  assign stall_o   = Rst & stall_int;
  assign bubble_o  = Rst & stall_int;
  assign flush_o   = Rst & flush_int;
  assign halted_o  = Rst & halted_int;
  assign fwd1_sel  = Rst ? fwd1_raw : '0;
  assign fwd2_sel  = Rst ? fwd2_raw : '0;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_up_hazard_ctrl.sv
// Bench for up_hazard_ctrl: directed vector table, halt/reset/saturation sequences
// and randomized traffic against an in-order pipeline-history model.
`timescale 1ns/1ps
module tb_up_hazard_ctrl;
  localparam int RADDR  = 3;
  localparam int NFWD   = 2;
  localparam int FSEL   = 2;
  localparam int CNTW   = 16;
  localparam int CNTW_S = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic             id_valid, id_use1, id_use2, id_wen, id_isload, id_branch_taken, id_halt;
  logic [RADDR-1:0] id_src1, id_src2, id_dest;

  logic              stall_o, bubble_o, flush_o, halted_o;
  logic [FSEL-1:0]   fwd1_sel, fwd2_sel;
  logic [CNTW-1:0]   stall_cnt;
  logic              s_stall_o, s_bubble_o, s_flush_o, s_halted_o;
  logic [FSEL-1:0]   s_fwd1_sel, s_fwd2_sel;
  logic [CNTW_S-1:0] s_stall_cnt;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  always #5 Clk = ~Clk;

  up_hazard_ctrl #(.RADDR(RADDR), .NFWD(NFWD), .FSEL(FSEL), .CNTW(CNTW)) dut (
    .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_wen(id_wen),
    .id_isload(id_isload), .id_branch_taken(id_branch_taken), .id_halt(id_halt),
    .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o), .fwd1_sel(fwd1_sel),
    .fwd2_sel(fwd2_sel), .halted_o(halted_o), .stall_cnt(stall_cnt));

  up_hazard_ctrl #(.RADDR(RADDR), .NFWD(NFWD), .FSEL(FSEL), .CNTW(CNTW_S)) dut_s (
    .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_wen(id_wen),
    .id_isload(id_isload), .id_branch_taken(id_branch_taken), .id_halt(id_halt),
    .stall_o(s_stall_o), .bubble_o(s_bubble_o), .flush_o(s_flush_o), .fwd1_sel(s_fwd1_sel),
    .fwd2_sel(s_fwd2_sel), .halted_o(s_halted_o), .stall_cnt(s_stall_cnt));

  typedef struct {
    logic       v;
    logic [2:0] s1, s2;
    logic       u1, u2;
    logic [2:0] d;
    logic       w, ld, br, h;
    logic       stall, flush;
    logic [1:0] f1, f2;
    logic       halted;
    int         cnt;
  } vec_t;

  function automatic vec_t mk(int v, int s1, int s2, int u1, int u2, int d, int w, int ld,
                              int br, int h, int st, int fl, int f1, int f2, int hl, int cnt);
    vec_t r;
    r.v = 1'(v); r.s1 = 3'(s1); r.s2 = 3'(s2); r.u1 = 1'(u1); r.u2 = 1'(u2);
    r.d = 3'(d); r.w = 1'(w); r.ld = 1'(ld); r.br = 1'(br); r.h = 1'(h);
    r.stall = 1'(st); r.flush = 1'(fl); r.f1 = 2'(f1); r.f2 = 2'(f2);
    r.halted = 1'(hl); r.cnt = cnt;
    return r;
  endfunction

  // Model: history of the last NFWD issued slots (index 0 = youngest) plus a mode and count.
  int m_v [NFWD];
  int m_w [NFWD];
  int m_d [NFWD];
  int m_ld[NFWD];
  int m_state;   // 0 running, 1 draining, 2 halted
  int m_cnt;

  function automatic bit m_hit(int k, int src, int u);
    return (m_v[k] != 0) && (m_w[k] != 0) && (m_d[k] == src) && (src != 0) && (u != 0);
  endfunction

  function automatic int m_sel(int src, int u);
    for (int k = 0; k < NFWD; k++) begin
      if (m_hit(k, src, u)) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit m_lu();
    return id_valid && (m_ld[0] != 0) &&
           (m_hit(0, int'(id_src1), int'(id_use1)) || m_hit(0, int'(id_src2), int'(id_use2)));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NFWD; k++) begin
      m_v[k] = 0; m_w[k] = 0; m_d[k] = 0; m_ld[k] = 0;
    end
    m_state = 0;
    m_cnt   = 0;
  endtask

  task automatic model_clock();
    bit lu, iss, was_empty;
    lu = m_lu();
    iss = (m_state == 0) && id_valid && !lu;
    was_empty = 1'b1;
    for (int k = 0; k < NFWD; k++) if (m_v[k] != 0) was_empty = 1'b0;
    if (m_state == 0 && lu) m_cnt++;
    for (int k = NFWD - 1; k > 0; k--) begin
      m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_d[k] = m_d[k-1]; m_ld[k] = m_ld[k-1];
    end
    m_v[0]  = iss ? 1 : 0;
    m_w[0]  = iss ? int'(id_wen) : 0;
    m_d[0]  = iss ? int'(id_dest) : 0;
    m_ld[0] = iss ? int'(id_isload) : 0;
    if (m_state == 0 && id_valid && id_halt && !lu) m_state = 1;
    else if (m_state == 1 && was_empty) m_state = 2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (txn %0d): got %0d, want %0d", name, txn, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.v; id_src1 = v.s1; id_src2 = v.s2; id_use1 = v.u1; id_use2 = v.u2;
    id_dest = v.d; id_wen = v.w; id_isload = v.ld; id_branch_taken = v.br; id_halt = v.h;
  endtask

  task automatic apply(input vec_t v);
    @(negedge Clk);
    drive(v);
    #1;
    txn++;
    $display("txn %0d: v=%0d src=%0d/%0d dest=%0d ld=%0d br=%0d h=%0d -> stall=%0d flush=%0d fwd=%0d/%0d halted=%0d cnt=%0d/%0d",
             txn, v.v, v.s1, v.s2, v.d, v.ld, v.br, v.h, stall_o, flush_o, fwd1_sel, fwd2_sel,
             halted_o, stall_cnt, s_stall_cnt);
  endtask

  task automatic check_model();
    int lu, es, ef, eh, c16, c4;
    lu  = m_lu() ? 1 : 0;
    es  = (m_state != 0) ? 1 : lu;
    ef  = (m_state == 0 && id_valid && id_branch_taken && !id_halt && lu == 0) ? 1 : 0;
    eh  = (m_state == 2) ? 1 : 0;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c4  = (m_cnt > 15) ? 15 : m_cnt;
    chk("stall", 32'(stall_o), 32'(es));
    chk("bubble", 32'(bubble_o), 32'(es));
    chk("flush", 32'(flush_o), 32'(ef));
    chk("fwd1", 32'(fwd1_sel), 32'(m_sel(int'(id_src1), int'(id_use1))));
    chk("fwd2", 32'(fwd2_sel), 32'(m_sel(int'(id_src2), int'(id_use2))));
    chk("halted", 32'(halted_o), 32'(eh));
    chk("cnt16", 32'(stall_cnt), 32'(c16));
    chk("cnt4", 32'(s_stall_cnt), 32'(c4));
  endtask

  task automatic step(input vec_t v);
    apply(v);
    check_model();
    model_clock();
  endtask

  // Drops reset wherever the caller is in the cycle, checks outputs at once, then releases.
  task automatic reset_now(input string tag);
    Rst = 1'b0;
    #1;
    txn++;
    $display("txn %0d: reset asserted (%s) -> stall=%0d halted=%0d cnt=%0d", txn, tag, stall_o, halted_o, stall_cnt);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_bubble"}, 32'(bubble_o), 32'd0);
    chk({tag, "_flush"}, 32'(flush_o), 32'd0);
    chk({tag, "_fwd"}, 32'({fwd1_sel, fwd2_sel}), 32'd0);
    chk({tag, "_halted"}, 32'(halted_o), 32'd0);
    chk({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, "_s_out"}, 32'({s_stall_o, s_bubble_o, s_flush_o, s_halted_o, s_fwd1_sel, s_fwd2_sel, s_stall_cnt}), 32'd0);
    @(negedge Clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    Rst = 1'b1;
    model_reset();
  endtask

  vec_t tbl [23];
  vec_t nop, ld4, use4, rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nop  = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
    ld4  = mk(1,0,0,0,0,4,1,1,0,0, 0,0,0,0,0,0);
    use4 = mk(1,4,4,1,1,5,1,0,0,0, 0,0,0,0,0,0);
    //          v s1 s2 u1 u2 d w ld br h   st fl f1 f2 hl cnt
    tbl[0]  = mk(1,2,3,1,1,1,1,0,0,0, 0,0,0,0,0,0);
    tbl[1]  = mk(1,1,3,1,1,2,1,0,0,0, 0,0,1,0,0,0);
    tbl[2]  = mk(1,7,7,1,1,6,1,0,0,0, 0,0,0,0,0,0);
    tbl[3]  = mk(1,2,0,1,1,3,1,0,0,0, 0,0,2,0,0,0);
    tbl[4]  = mk(1,0,0,1,1,1,1,0,0,0, 0,0,0,0,0,0);
    tbl[5]  = mk(1,5,5,1,1,1,1,0,0,0, 0,0,0,0,0,0);
    tbl[6]  = mk(1,1,1,1,1,0,1,0,0,0, 0,0,1,1,0,0);
    tbl[7]  = mk(1,0,1,1,1,3,1,0,0,0, 0,0,0,2,0,0);
    tbl[8]  = mk(1,0,0,1,0,4,1,1,0,0, 0,0,0,0,0,0);
    tbl[9]  = mk(1,4,4,1,1,5,1,0,0,0, 1,0,1,1,0,0);
    tbl[10] = mk(1,4,4,1,1,5,1,0,0,0, 0,0,2,2,0,1);
    tbl[11] = mk(1,0,0,0,0,4,1,1,0,0, 0,0,0,0,0,1);
    tbl[12] = mk(1,4,0,1,0,0,0,0,1,0, 1,0,1,0,0,1);
    tbl[13] = mk(1,4,0,1,0,0,0,0,1,0, 0,1,2,0,0,2);
    tbl[14] = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,2);
    tbl[15] = mk(1,0,0,1,1,1,1,0,0,0, 0,0,0,0,0,2);
    tbl[16] = mk(1,0,0,1,1,2,1,0,0,0, 0,0,0,0,0,2);
    tbl[17] = mk(1,1,0,1,0,0,0,0,1,1, 0,0,2,0,0,2);
    tbl[18] = mk(1,2,0,1,0,7,1,0,0,0, 1,0,2,0,0,2);
    tbl[19] = mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,2);
    tbl[20] = mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,2);
    tbl[21] = mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,1,2);
    tbl[22] = mk(1,4,4,1,1,4,1,1,1,0, 1,0,0,0,1,2);

    drive(nop);
    model_reset();
    repeat (2) @(posedge Clk);
    #2;
    reset_now("por");

    // Directed table: forwarding, youngest-wins, r0, load-use, stall+branch, halt drain.
    for (int i = 0; i < 23; i++) begin
      apply(tbl[i]);
      chk($sformatf("tbl%0d_stall", i), 32'(stall_o), 32'(tbl[i].stall));
      chk($sformatf("tbl%0d_bubble", i), 32'(bubble_o), 32'(tbl[i].stall));
      chk($sformatf("tbl%0d_flush", i), 32'(flush_o), 32'(tbl[i].flush));
      chk($sformatf("tbl%0d_fwd1", i), 32'(fwd1_sel), 32'(tbl[i].f1));
      chk($sformatf("tbl%0d_fwd2", i), 32'(fwd2_sel), 32'(tbl[i].f2));
      chk($sformatf("tbl%0d_halted", i), 32'(halted_o), 32'(tbl[i].halted));
      chk($sformatf("tbl%0d_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
      model_clock();
    end

    // One-cycle reset out of HALTED, then the pipeline runs again.
    @(negedge Clk);
    #2;
    reset_now("halt_rst");
    step(mk(1,0,0,1,1,1,1,0,0,0, 0,0,0,0,0,0));
    step(mk(1,1,0,1,0,2,1,0,0,0, 0,0,0,0,0,0));

    // Twenty load-use pairs: the 4-bit counter must pin at 15.
    for (int p = 0; p < 20; p++) begin
      step(ld4);
      step(use4);
      step(use4);
    end
    apply(nop);
    chk("sat_cnt4", 32'(s_stall_cnt), 32'd15);
    chk("sat_cnt16", 32'(stall_cnt), 32'd20);
    check_model();
    model_clock();

    // Asynchronous reset in the middle of a load-use stall cycle.
    step(ld4);
    apply(use4);
    chk("pre_rst_stall", 32'(stall_o), 32'd1);
    #2;
    reset_now("async");

    // Randomized traffic against the model; halted runs are ended by reset.
    begin
      int hc;
      hc = 0;
      for (int i = 0; i < 400; i++) begin
        rv = mk(($urandom_range(0, 7) != 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                ($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
                ($urandom_range(0, 5) == 0) ? 1 : 0, ($urandom_range(0, 29) == 0) ? 1 : 0,
                0,0,0,0,0,0);
        step(rv);
        if (m_state == 2) begin
          hc++;
          if (hc >= 2) begin
            hc = 0;
            @(negedge Clk);
            #2;
            reset_now("rand_rst");
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
